control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/control_unit_if.sv | 34 +++
 rtl/cu_decode.sv | 40 ++++
 rtl/control_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit state encoding, opcode constants and
// the instruction classes produced by the opcode decoder.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    IC_LD    = 3'd0,
    IC_LDI   = 3'd1,
    IC_ST    = 3'd2,
    IC_ALU_R = 3'd3,
    IC_ADDI  = 3'd4,
    IC_HALT  = 3'd5,
    IC_NOP   = 3'd6
  } iclass_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_sel_e;

  // Complete set of control strobes for one state.
  typedef struct packed {
    logic pc_out;
    logic mdr_out;
    logic zlow_out;
    logic zhigh_out;
    logic c_out;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic inc_pc;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic read;
    logic write_mem;
    logic alu_add;
    logic alu_sub;
    logic alu_and;
    logic alu_or;
    logic run;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bus: instruction/memory inputs and every datapath strobe.
interface control_unit_if;

  logic [31:0] ir;
  logic        mem_ready;

  logic PCout, MDRout, Zlowout, Zhighout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, IncPC;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic Read, write_mem;
  logic ADD, SUB, AND, OR;
  logic run;

  modport master (
    output ir, mem_ready,
    input  PCout, MDRout, Zlowout, Zhighout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, IncPC,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  Read, write_mem,
    input  ADD, SUB, AND, OR,
    input  run
  );

  modport slave (
    input  ir, mem_ready,
    output PCout, MDRout, Zlowout, Zhighout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, IncPC,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output Read, write_mem,
    output ADD, SUB, AND, OR,
    output run
  );

endinterface

// File: rtl/cu_decode.sv
// Opcode decoder: maps a 5-bit opcode to an instruction class and ALU select.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_e    iclass_o,
  output alu_sel_e   alu_sel_o
);

  // Unlisted opcodes fall through to NOP so an illegal word simply refetches.
  always_comb begin
    iclass_o  = IC_NOP;
    alu_sel_o = ALU_ADD;
    case (opcode_i)
      OP_LD:   iclass_o = IC_LD;
      OP_LDI:  iclass_o = IC_LDI;
      OP_ST:   iclass_o = IC_ST;
      OP_ADD: begin
        iclass_o  = IC_ALU_R;
        alu_sel_o = ALU_ADD;
      end
      OP_SUB: begin
        iclass_o  = IC_ALU_R;
        alu_sel_o = ALU_SUB;
      end
      OP_AND: begin
        iclass_o  = IC_ALU_R;
        alu_sel_o = ALU_AND;
      end
      OP_OR: begin
        iclass_o  = IC_ALU_R;
        alu_sel_o = ALU_OR;
      end
      OP_ADDI: iclass_o = IC_ADDI;
      OP_HALT: iclass_o = IC_HALT;
      default: iclass_o = IC_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit sequencing fetch/execute states T0..T7 plus IDLE/HALT.
// Optional feature macro CU_MEM_WAIT_EN: stall memory states until mem_ready.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  control_unit_if.slave  cu_bus
);

  state_e   state_q, state_d;
  iclass_e  iclass;
  alu_sel_e alu_sel;
  ctrl_t    ctrl;
  logic     mem_wait;

  cu_decode u_decode (
    .opcode_i  (cu_bus.ir[31:27]),
    .iclass_o  (iclass),
    .alu_sel_o (alu_sel)
  );

  logic unused_ir_low;
  assign unused_ir_low = ^cu_bus.ir[26:0];

`ifdef CU_MEM_WAIT_EN
  assign mem_wait = ~cu_bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = cu_bus.mem_ready;
  assign mem_wait         = 1'b0;
`endif

  // State register; reset wins over any pending stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_wait ? S_T1 : S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (iclass == IC_HALT) begin
          state_d = S_HALT;
        end else if (iclass == IC_NOP) begin
          state_d = S_T0;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        if ((iclass == IC_LD) || (iclass == IC_ST)) begin
          state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if ((iclass == IC_LD) && mem_wait) begin
          state_d = S_T6;
        end else begin
          state_d = S_T7;
        end
      end
      S_T7: begin
        if ((iclass == IC_ST) && mem_wait) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode from the present state (execute states qualified by class).
  always_comb begin
    ctrl     = CTRL_NONE;
    ctrl.run = (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        ctrl.inc_pc = 1'b1;
        ctrl.pc_in  = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      S_T1: begin
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      S_T3: begin
        case (iclass)
          IC_LD, IC_LDI, IC_ST: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          IC_ALU_R, IC_ADDI: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          default: ctrl.y_in = 1'b0;
        endcase
      end
      S_T4: begin
        case (iclass)
          IC_ALU_R: begin
            ctrl.grc     = 1'b1;
            ctrl.r_out   = 1'b1;
            ctrl.z_in    = 1'b1;
            ctrl.alu_add = (alu_sel == ALU_ADD);
            ctrl.alu_sub = (alu_sel == ALU_SUB);
            ctrl.alu_and = (alu_sel == ALU_AND);
            ctrl.alu_or  = (alu_sel == ALU_OR);
          end
          IC_LD, IC_LDI, IC_ST, IC_ADDI: begin
            ctrl.c_out   = 1'b1;
            ctrl.alu_add = 1'b1;
            ctrl.z_in    = 1'b1;
          end
          default: ctrl.z_in = 1'b0;
        endcase
      end
      S_T5: begin
        case (iclass)
          IC_LD, IC_ST: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
          end
          IC_LDI, IC_ALU_R, IC_ADDI: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
          end
          default: ctrl.zlow_out = 1'b0;
        endcase
      end
      S_T6: begin
        case (iclass)
          IC_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          IC_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          default: ctrl.mdr_in = 1'b0;
        endcase
      end
      S_T7: begin
        case (iclass)
          IC_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          IC_ST:   ctrl.write_mem = 1'b1;
          default: ctrl.write_mem = 1'b0;
        endcase
      end
      default: ctrl.run = (state_q != S_HALT);
    endcase
  end

  assign cu_bus.PCout     = ctrl.pc_out;
  assign cu_bus.MDRout    = ctrl.mdr_out;
  assign cu_bus.Zlowout   = ctrl.zlow_out;
  assign cu_bus.Zhighout  = ctrl.zhigh_out;
  assign cu_bus.Cout      = ctrl.c_out;
  assign cu_bus.PCin      = ctrl.pc_in;
  assign cu_bus.IRin      = ctrl.ir_in;
  assign cu_bus.MARin     = ctrl.mar_in;
  assign cu_bus.MDRin     = ctrl.mdr_in;
  assign cu_bus.Yin       = ctrl.y_in;
  assign cu_bus.Zin       = ctrl.z_in;
  assign cu_bus.IncPC     = ctrl.inc_pc;
  assign cu_bus.Gra       = ctrl.gra;
  assign cu_bus.Grb       = ctrl.grb;
  assign cu_bus.Grc       = ctrl.grc;
  assign cu_bus.Rin       = ctrl.r_in;
  assign cu_bus.Rout      = ctrl.r_out;
  assign cu_bus.BAout     = ctrl.ba_out;
  assign cu_bus.Read      = ctrl.read;
  assign cu_bus.write_mem = ctrl.write_mem;
  assign cu_bus.ADD       = ctrl.alu_add;
  assign cu_bus.SUB       = ctrl.alu_sub;
  assign cu_bus.AND       = ctrl.alu_and;
  assign cu_bus.OR        = ctrl.alu_or;
  assign cu_bus.run       = ctrl.run;

endmodule
